// File: rtl/axil_dual_port_ram.sv
// -----------------------------------------------------------------------------
// axil_dual_port_ram
//   Single-clock true dual-port RAM behind two independent AXI4-Lite slave
//   ports. Port A faces the CPU interconnect, port B the external loader; both
//   have full read/write access to one shared word array.
//
// Ports (x = a | b, identical per port):
//   clk, rst            single clock, synchronous active-high reset
//   s_axil_x_aw*        write address channel (awprot ignored)
//   s_axil_x_w*         write data channel with byte strobes
//   s_axil_x_b*         write response channel, bresp always OKAY
//   s_axil_x_ar*        read address channel (arprot ignored)
//   s_axil_x_r*         read data channel, rresp always OKAY
//
// Notes:
//   - AW and W are only ever accepted together, one write per two cycles max.
//   - Reads and writes landing on the same edge see the old word contents.
//   - On a same-edge A/B write collision, port B wins per byte; bytes enabled
//     only on port A are still written.
//   - The word array has no reset; it powers up zeroed (zero-initialised
//     simulation state / FPGA block RAM init value).
// -----------------------------------------------------------------------------
module axil_dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // port A
    input  logic [ADDR_WIDTH-1:0] s_axil_a_awaddr,
    input  logic [2:0]            s_axil_a_awprot,
    input  logic                  s_axil_a_awvalid,
    output logic                  s_axil_a_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_a_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_a_wstrb,
    input  logic                  s_axil_a_wvalid,
    output logic                  s_axil_a_wready,
    output logic [1:0]            s_axil_a_bresp,
    output logic                  s_axil_a_bvalid,
    input  logic                  s_axil_a_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_a_araddr,
    input  logic [2:0]            s_axil_a_arprot,
    input  logic                  s_axil_a_arvalid,
    output logic                  s_axil_a_arready,
    output logic [DATA_WIDTH-1:0] s_axil_a_rdata,
    output logic [1:0]            s_axil_a_rresp,
    output logic                  s_axil_a_rvalid,
    input  logic                  s_axil_a_rready,
    // port B
    input  logic [ADDR_WIDTH-1:0] s_axil_b_awaddr,
    input  logic [2:0]            s_axil_b_awprot,
    input  logic                  s_axil_b_awvalid,
    output logic                  s_axil_b_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_b_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_b_wstrb,
    input  logic                  s_axil_b_wvalid,
    output logic                  s_axil_b_wready,
    output logic [1:0]            s_axil_b_bresp,
    output logic                  s_axil_b_bvalid,
    input  logic                  s_axil_b_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_b_araddr,
    input  logic [2:0]            s_axil_b_arprot,
    input  logic                  s_axil_b_arvalid,
    output logic                  s_axil_b_arready,
    output logic [DATA_WIDTH-1:0] s_axil_b_rdata,
    output logic [1:0]            s_axil_b_rresp,
    output logic                  s_axil_b_rvalid,
    input  logic                  s_axil_b_rready
);

    localparam int WORD_LSB  = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH = ADDR_WIDTH - WORD_LSB;
    localparam int DEPTH     = 2 ** IDX_WIDTH;
    localparam int NPORT     = 2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // per-port views of the two AXI ports (index 0 = A, 1 = B)
    logic [IDX_WIDTH-1:0]  aw_idx_s [NPORT];
    logic [IDX_WIDTH-1:0]  ar_idx_s [NPORT];
    logic [DATA_WIDTH-1:0] wdata_s  [NPORT];
    logic [STRB_WIDTH-1:0] wstrb_s  [NPORT];
    logic [NPORT-1:0]      awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;

    logic [NPORT-1:0]      aw_ready_d, aw_ready_q;
    logic [NPORT-1:0]      bvalid_d, bvalid_q;
    logic [NPORT-1:0]      ar_ready_d, ar_ready_q;
    logic [NPORT-1:0]      rvalid_d, rvalid_q;
    logic [NPORT-1:0]      wr_en_s, rd_en_s;
    logic [DATA_WIDTH-1:0] rdata_q  [NPORT];

    logic                  unused_s;

    assign aw_idx_s[0]  = s_axil_a_awaddr[ADDR_WIDTH-1:WORD_LSB];
    assign aw_idx_s[1]  = s_axil_b_awaddr[ADDR_WIDTH-1:WORD_LSB];
    assign ar_idx_s[0]  = s_axil_a_araddr[ADDR_WIDTH-1:WORD_LSB];
    assign ar_idx_s[1]  = s_axil_b_araddr[ADDR_WIDTH-1:WORD_LSB];
    assign wdata_s[0]   = s_axil_a_wdata;
    assign wdata_s[1]   = s_axil_b_wdata;
    assign wstrb_s[0]   = s_axil_a_wstrb;
    assign wstrb_s[1]   = s_axil_b_wstrb;
    assign awvalid_s    = {s_axil_b_awvalid, s_axil_a_awvalid};
    assign wvalid_s     = {s_axil_b_wvalid,  s_axil_a_wvalid};
    assign bready_s     = {s_axil_b_bready,  s_axil_a_bready};
    assign arvalid_s    = {s_axil_b_arvalid, s_axil_a_arvalid};
    assign rready_s     = {s_axil_b_rready,  s_axil_a_rready};

    // protection bits and byte-offset address bits carry no meaning here
    assign unused_s = ^{s_axil_a_awprot, s_axil_a_arprot, s_axil_b_awprot, s_axil_b_arprot,
                        s_axil_a_awaddr[WORD_LSB-1:0], s_axil_a_araddr[WORD_LSB-1:0],
                        s_axil_b_awaddr[WORD_LSB-1:0], s_axil_b_araddr[WORD_LSB-1:0]};

    // Next-state logic for the handshake/response flags of each port.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            // the ready pulse is the accept cycle; the commit is on its closing edge
            wr_en_s[p] = aw_ready_q[p] && awvalid_s[p] && wvalid_s[p];
            rd_en_s[p] = ar_ready_q[p] && arvalid_s[p];

            // accept only when the response slot will be free by commit time
            aw_ready_d[p] = !aw_ready_q[p] && awvalid_s[p] && wvalid_s[p]
                            && (!bvalid_q[p] || bready_s[p]);
            ar_ready_d[p] = !ar_ready_q[p] && arvalid_s[p]
                            && (!rvalid_q[p] || rready_s[p]);

            if (wr_en_s[p]) begin
                bvalid_d[p] = 1'b1;
            end else if (bready_s[p]) begin
                bvalid_d[p] = 1'b0;
            end else begin
                bvalid_d[p] = bvalid_q[p];
            end

            if (rd_en_s[p]) begin
                rvalid_d[p] = 1'b1;
            end else if (rready_s[p]) begin
                rvalid_d[p] = 1'b0;
            end else begin
                rvalid_d[p] = rvalid_q[p];
            end
        end
    end

    // Handshake and response flag registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_ready_q <= {NPORT{1'b0}};
            bvalid_q   <= {NPORT{1'b0}};
            ar_ready_q <= {NPORT{1'b0}};
            rvalid_q   <= {NPORT{1'b0}};
        end else begin
            aw_ready_q <= aw_ready_d;
            bvalid_q   <= bvalid_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Byte-masked array writes; port B is applied last so it wins collisions.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!rst && wr_en_s[p]) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (wstrb_s[p][b]) begin
                        mem[aw_idx_s[p]][b*8 +: 8] <= wdata_s[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    // Registered read data; non-blocking read returns pre-write contents.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (rst) begin
                rdata_q[p] <= {DATA_WIDTH{1'b0}};
            end else if (rd_en_s[p]) begin
                rdata_q[p] <= mem[ar_idx_s[p]];
            end
        end
    end

    assign s_axil_a_awready = aw_ready_q[0];
    assign s_axil_a_wready  = aw_ready_q[0];
    assign s_axil_a_bresp   = 2'b00;
    assign s_axil_a_bvalid  = bvalid_q[0];
    assign s_axil_a_arready = ar_ready_q[0];
    assign s_axil_a_rdata   = rdata_q[0];
    assign s_axil_a_rresp   = 2'b00;
    assign s_axil_a_rvalid  = rvalid_q[0];

    assign s_axil_b_awready = aw_ready_q[1];
    assign s_axil_b_wready  = aw_ready_q[1];
    assign s_axil_b_bresp   = 2'b00;
    assign s_axil_b_bvalid  = bvalid_q[1];
    assign s_axil_b_arready = ar_ready_q[1];
    assign s_axil_b_rdata   = rdata_q[1];
    assign s_axil_b_rresp   = 2'b00;
    assign s_axil_b_rvalid  = rvalid_q[1];

endmodule

// File: tb/tb_axil_dual_port_ram.sv
// -----------------------------------------------------------------------------
// tb_axil_dual_port_ram
//   Self-checking bench for axil_dual_port_ram: directed scenarios followed by
//   randomized concurrent traffic on both ports, checked against a word-level
//   reference memory (associative array, unwritten words read as zero).
// -----------------------------------------------------------------------------
module tb_axil_dual_port_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] awaddr [2];
    logic [16:0] araddr [2];
    logic [2:0]  awprot [2];
    logic [2:0]  arprot [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    logic [1:0]  awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp  [2];
    logic [1:0]  rresp  [2];
    logic [31:0] rdata  [2];

    // transaction parameters consumed by run_xact
    logic [16:0] w_addr [2];
    logic [31:0] w_data [2];
    logic [3:0]  w_strb [2];
    logic [16:0] r_addr [2];
    logic [31:0] last_rd [2];

    logic [31:0] mdl [int];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axil_dual_port_ram dut (
        .clk(clk), .rst(rst),
        .s_axil_a_awaddr(awaddr[0]), .s_axil_a_awprot(awprot[0]), .s_axil_a_awvalid(awvalid[0]),
        .s_axil_a_awready(awready[0]), .s_axil_a_wdata(wdata[0]), .s_axil_a_wstrb(wstrb[0]),
        .s_axil_a_wvalid(wvalid[0]), .s_axil_a_wready(wready[0]), .s_axil_a_bresp(bresp[0]),
        .s_axil_a_bvalid(bvalid[0]), .s_axil_a_bready(bready[0]), .s_axil_a_araddr(araddr[0]),
        .s_axil_a_arprot(arprot[0]), .s_axil_a_arvalid(arvalid[0]), .s_axil_a_arready(arready[0]),
        .s_axil_a_rdata(rdata[0]), .s_axil_a_rresp(rresp[0]), .s_axil_a_rvalid(rvalid[0]),
        .s_axil_a_rready(rready[0]),
        .s_axil_b_awaddr(awaddr[1]), .s_axil_b_awprot(awprot[1]), .s_axil_b_awvalid(awvalid[1]),
        .s_axil_b_awready(awready[1]), .s_axil_b_wdata(wdata[1]), .s_axil_b_wstrb(wstrb[1]),
        .s_axil_b_wvalid(wvalid[1]), .s_axil_b_wready(wready[1]), .s_axil_b_bresp(bresp[1]),
        .s_axil_b_bvalid(bvalid[1]), .s_axil_b_bready(bready[1]), .s_axil_b_araddr(araddr[1]),
        .s_axil_b_arprot(arprot[1]), .s_axil_b_arvalid(arvalid[1]), .s_axil_b_arready(arready[1]),
        .s_axil_b_rdata(rdata[1]), .s_axil_b_rresp(rresp[1]), .s_axil_b_rvalid(rvalid[1]),
        .s_axil_b_rready(rready[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [16:0] a);
        int w;
        w = int'(a) / 4;
        if (mdl.exists(w)) return mdl[w];
        return 32'h0;
    endfunction

    task automatic mdl_wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = mdl_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        end
        mdl[int'(a) / 4] = cur;
    endtask

    // Start writes on ports in wm and reads on ports in rm in the same cycle,
    // check the handshake timing, responses and read data, optionally stalling
    // rready for rhold cycles; skip_resp leaves the write response pending.
    task automatic run_xact(input logic [1:0] wm, input logic [1:0] rm,
                            input int rhold, input bit skip_resp);
        logic [31:0] exp_rd [2];
        int          n;
        for (int p = 0; p < 2; p++) begin
            if (wm[p]) begin
                awaddr[p] = w_addr[p]; wdata[p] = w_data[p]; wstrb[p] = w_strb[p];
                awprot[p] = 3'($urandom_range(0, 7));
                awvalid[p] = 1'b1; wvalid[p] = 1'b1;
            end
            if (rm[p]) begin
                araddr[p] = r_addr[p];
                arprot[p] = 3'($urandom_range(0, 7));
                arvalid[p] = 1'b1;
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((awready & wm) != wm) || ((arready & rm) != rm)) && n < 16);
        chk("ready_latency", 64'(n), 64'd1);
        chk("wready", 64'(wready & wm), 64'(wm));
        for (int p = 0; p < 2; p++) exp_rd[p] = mdl_rd(r_addr[p]);
        @(negedge clk);
        awvalid = awvalid & ~wm;
        wvalid  = wvalid & ~wm;
        if (rhold == 0) arvalid = arvalid & ~rm;
        chk("awready_pulse", 64'(awready & wm), 64'd0);
        chk("bvalid", 64'(bvalid & wm), 64'(wm));
        for (int p = 0; p < 2; p++) begin
            if (wm[p]) begin
                chk("bresp", 64'(bresp[p]), 64'd0);
                mdl_wr(w_addr[p], w_data[p], w_strb[p]);
            end
            if (rm[p]) begin
                last_rd[p] = rdata[p];
                chk("rvalid", 64'(rvalid[p]), 64'd1);
                chk("rdata", 64'(rdata[p]), 64'(exp_rd[p]));
                chk("rresp", 64'(rresp[p]), 64'd0);
            end
        end
        for (int h = 0; h < rhold; h++) begin
            @(negedge clk);
            chk("hold_rvalid", 64'(rvalid & rm), 64'(rm));
            chk("hold_arready", 64'(arready & rm), 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (rm[p]) chk("hold_rdata", 64'(rdata[p]), 64'(exp_rd[p]));
            end
        end
        arvalid = arvalid & ~rm;
        rready  = rm;
        if (!skip_resp) bready = wm;
        @(negedge clk);
        rready = 2'b00;
        bready = 2'b00;
        chk("rvalid_clr", 64'(rvalid & rm), 64'd0);
        if (!skip_resp) chk("bvalid_clr", 64'(bvalid & wm), 64'd0);
    endtask

    function automatic logic [16:0] rnd_addr();
        logic [16:0] a;
        a = (17'($urandom_range(0, 15)) << 2) | 17'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a | 17'h1FFC0;
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        awvalid = 2'b00; wvalid = 2'b00; bready = 2'b00; arvalid = 2'b00; rready = 2'b00;
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = 17'h0; araddr[p] = 17'h0; awprot[p] = 3'h0; arprot[p] = 3'h0;
            wdata[p] = 32'h0; wstrb[p] = 4'h0; w_addr[p] = 17'h0; w_data[p] = 32'h0;
            w_strb[p] = 4'h0; r_addr[p] = 17'h0; last_rd[p] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rdata_a", 64'(rdata[0]), 64'd0);
        chk("rst_rdata_b", 64'(rdata[1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // B writes, A reads back
        w_addr[1] = 17'h0; w_data[1] = 32'hDEADBEEF; w_strb[1] = 4'hF;
        run_xact(2'b10, 2'b00, 0, 1'b0);
        r_addr[0] = 17'h0;
        run_xact(2'b00, 2'b01, 0, 1'b0);
        chk("t1_rdata", 64'(last_rd[0]), 64'hDEADBEEF);

        // partial-strobe overwrite
        w_addr[0] = 17'h4; w_data[0] = 32'h11223344; w_strb[0] = 4'hF;
        run_xact(2'b01, 2'b00, 0, 1'b0);
        w_data[0] = 32'hAABBCCDD; w_strb[0] = 4'b0101;
        run_xact(2'b01, 2'b00, 0, 1'b0);
        r_addr[0] = 17'h4;
        run_xact(2'b00, 2'b01, 0, 1'b0);
        chk("t2_rdata", 64'(last_rd[0]), 64'h11BB33DD);

        // read stalled by rready for 5 cycles
        w_addr[1] = 17'h8; w_data[1] = 32'h5A5AA5A5; w_strb[1] = 4'hF;
        run_xact(2'b10, 2'b00, 0, 1'b0);
        r_addr[0] = 17'h8;
        run_xact(2'b00, 2'b01, 5, 1'b0);
        chk("t3_rdata", 64'(last_rd[0]), 64'h5A5AA5A5);

        // same-edge A/B write collision
        w_addr[0] = 17'hC; w_data[0] = 32'h00000001; w_strb[0] = 4'hF;
        w_addr[1] = 17'hC; w_data[1] = 32'hFFFF0000; w_strb[1] = 4'b1100;
        run_xact(2'b11, 2'b00, 0, 1'b0);
        r_addr[1] = 17'hC;
        run_xact(2'b00, 2'b10, 0, 1'b0);
        chk("t4_rdata", 64'(last_rd[1]), 64'hFFFF0001);

        // byte-offset aliasing and top of address space
        w_addr[0] = 17'h10; w_data[0] = 32'hCAFEF00D; w_strb[0] = 4'hF;
        run_xact(2'b01, 2'b00, 0, 1'b0);
        r_addr[1] = 17'h13;
        run_xact(2'b00, 2'b10, 0, 1'b0);
        chk("t5_alias", 64'(last_rd[1]), 64'hCAFEF00D);
        w_addr[1] = 17'h1FFFC; w_data[1] = 32'h13579BDF; w_strb[1] = 4'hF;
        run_xact(2'b10, 2'b00, 0, 1'b0);
        r_addr[0] = 17'h0; r_addr[1] = 17'h1FFFC;
        run_xact(2'b00, 2'b11, 0, 1'b0);
        chk("t5_low", 64'(last_rd[0]), 64'hDEADBEEF);
        chk("t5_high", 64'(last_rd[1]), 64'h13579BDF);

        // read and write of the same word on the same edge return old data
        w_addr[0] = 17'h4; w_data[0] = 32'h55667788; w_strb[0] = 4'hF;
        r_addr[0] = 17'h4; r_addr[1] = 17'h4;
        run_xact(2'b01, 2'b11, 0, 1'b0);
        chk("rdw_same_port", 64'(last_rd[0]), 64'h11BB33DD);
        chk("rdw_cross_port", 64'(last_rd[1]), 64'h11BB33DD);

        // AW or W alone is never accepted
        awaddr[0] = 17'h30; awvalid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("aw_alone", 64'(awready[0]), 64'd0);
        awvalid[0] = 1'b0; wvalid[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("w_alone", 64'(wready[1]), 64'd0);
        wvalid[1] = 1'b0;
        @(negedge clk);

        // reset with a pending response and a blocked write
        w_addr[0] = 17'h20; w_data[0] = 32'h0BADF00D; w_strb[0] = 4'hF;
        run_xact(2'b01, 2'b00, 0, 1'b1);
        awaddr[0] = 17'h24; wdata[0] = 32'h600DCAFE; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        chk("t6_blocked", 64'(awready[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_bvalid", 64'(bvalid[0]), 64'd0);
        chk("t6_awready", 64'(awready[0]), 64'd0);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; rst = 1'b0;
        @(negedge clk);
        r_addr[0] = 17'h20; r_addr[1] = 17'h24;
        run_xact(2'b00, 2'b11, 0, 1'b0);
        chk("t6_kept", 64'(last_rd[0]), 64'h0BADF00D);
        chk("t6_dropped", 64'(last_rd[1]), 64'h0);
        w_addr[1] = 17'h24; w_data[1] = 32'h600DCAFE; w_strb[1] = 4'hF;
        run_xact(2'b10, 2'b00, 0, 1'b0);
        r_addr[0] = 17'h24;
        run_xact(2'b00, 2'b01, 0, 1'b0);
        chk("t6_fresh", 64'(last_rd[0]), 64'h600DCAFE);

        // randomized concurrent traffic against the reference memory
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < 2; p++) begin
                w_addr[p] = rnd_addr();
                w_data[p] = $urandom;
                w_strb[p] = 4'($urandom_range(0, 15));
                r_addr[p] = rnd_addr();
            end
            run_xact(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     $urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
